// File: rtl/uart_reg_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_reg_responder_if : rx byte stream in, tx response byte out       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface uart_reg_responder_if;
  logic [7:0] i_rx_data;
  logic       i_rx_dv;
  logic [7:0] o_tx_data;
  logic       o_tx_dv;
  logic       i_tx_busy;

  // Host/UART side: supplies received bytes and tx busy, consumes responses.
  modport master (
    output i_rx_data, i_rx_dv, i_tx_busy,
    input  o_tx_data, o_tx_dv
  );

  modport slave (
    input  i_rx_data, i_rx_dv, i_tx_busy,
    output o_tx_data, o_tx_dv
  );
endinterface
`default_nettype wire

// File: rtl/uart_reg_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_reg_responder : 'W'/'R' byte-command register bank responder     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_reg_responder #(
  parameter int NREGS   = 16,
  parameter int TIMEOUT = 100000
) (
  input  wire logic                 clk,
  input  wire logic                 i_reset,
  uart_reg_responder_if.slave       bus,
  output logic [NREGS*8-1:0]        o_regs,
  output logic                      o_overrun
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] c_op_w   = 8'h57;
  localparam logic [7:0] c_op_r   = 8'h52;
  localparam logic [7:0] c_rsp_ok = 8'h4B;
  localparam logic [7:0] c_rsp_q  = 8'h3F;
  localparam logic [7:0] c_rsp_e  = 8'h45;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      resp_q, resp_d;
  logic            tx_dv_q, tx_dv_d;
  logic            overrun_q, overrun_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      regs_q [NREGS];
  logic [7:0]      regs_d [NREGS];

  logic [7:0]      w_rd_data;
  logic            w_rx_in_range;
  logic            w_addr_in_range;

  // Address is compared as a full 8-bit value so 0x10..0xFF never alias.
  assign w_rx_in_range   = ({1'b0, bus.i_rx_data} < 9'(NREGS));
  assign w_addr_in_range = ({1'b0, addr_q} < 9'(NREGS));

  always_comb begin
    w_rd_data = 8'h00;
    for (int k = 0; k < NREGS; k++) begin
      if (bus.i_rx_data == 8'(k)) w_rd_data = regs_q[k];
    end
  end

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    resp_d    = resp_q;
    tx_dv_d   = 1'b0;
    overrun_d = 1'b0;
    tmo_d     = '0;
    regs_d    = regs_q;

    // Partial-command timeout; an arriving byte in the same cycle wins.
    if ((state_q == S_ADDR || state_q == S_DATA) && !bus.i_rx_dv) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
      end else if (tmo_q != TW'(TIMEOUT)) begin
        tmo_d = tmo_q + TW'(1);
      end else begin
        tmo_d = tmo_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_rx_dv) begin
          if (bus.i_rx_data == c_op_w || bus.i_rx_data == c_op_r) begin
            is_wr_d = (bus.i_rx_data == c_op_w);
            state_d = S_ADDR;
          end else begin
            resp_d  = c_rsp_q;
            state_d = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (bus.i_rx_dv) begin
          addr_d = bus.i_rx_data;
          if (is_wr_q) begin
            state_d = S_DATA;
          end else begin
            resp_d  = w_rx_in_range ? w_rd_data : c_rsp_e;
            state_d = S_RESP;
          end
        end
      end
      S_DATA: begin
        if (bus.i_rx_dv) begin
          if (w_addr_in_range) begin
            for (int k = 0; k < NREGS; k++) begin
              if (addr_q == 8'(k)) regs_d[k] = bus.i_rx_data;
            end
            resp_d = c_rsp_ok;
          end else begin
            resp_d = c_rsp_e;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        overrun_d = bus.i_rx_dv;
        if (!bus.i_tx_busy) begin
          tx_dv_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      addr_q    <= 8'h00;
      resp_q    <= 8'h00;
      tx_dv_q   <= 1'b0;
      overrun_q <= 1'b0;
      tmo_q     <= '0;
      regs_q    <= '{default: 8'h00};
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      resp_q    <= resp_d;
      tx_dv_q   <= tx_dv_d;
      overrun_q <= overrun_d;
      tmo_q     <= tmo_d;
      regs_q    <= regs_d;
    end
  end

  assign bus.o_tx_data = resp_q;
  assign bus.o_tx_dv   = tx_dv_q;
  assign o_overrun     = overrun_q;

  for (genvar k = 0; k < NREGS; k++) begin : g_regs
    assign o_regs[8*k +: 8] = regs_q[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_reg_responder : directed bench for uart_reg_responder         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_uart_reg_responder;
  localparam int NREGS   = 16;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_reg_responder_if bus();
  logic [NREGS*8-1:0] regs;
  logic               overrun;

  uart_reg_responder #(.NREGS(NREGS), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .i_reset   (rst),
    .bus       (bus),
    .o_regs    (regs),
    .o_overrun (overrun)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] model [NREGS];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int k = 0; k < NREGS; k++) f[8*k +: 8] = model[k];
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_dv   = 1'b1;
    @(negedge clk);
    bus.i_rx_dv   = 1'b0;
  endtask

  // Waits for one response; exp_lat > 0 also pins the cycle it appears in.
  task automatic get_resp(input string tag, input logic [7:0] exp, input int exp_lat);
    int  n;
    logic found;
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.o_tx_dv) found = 1'b1;
    end
    check({tag, "_seen"}, found, 1'b1);
    if (found) begin
      check({tag, "_data"}, bus.o_tx_data, exp);
      if (exp_lat > 0) check({tag, "_lat"}, n, exp_lat);
      @(negedge clk);
      check({tag, "_pulse"}, bus.o_tx_dv, 1'b0);
    end
  endtask

  task automatic quiet(input string tag, input int ncyc);
    int cnt;
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.o_tx_dv) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ov, dvc;
    bus.i_rx_data = 8'h00;
    bus.i_rx_dv   = 1'b0;
    bus.i_tx_busy = 1'b0;
    for (int k = 0; k < NREGS; k++) model[k] = 8'h00;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_regs", regs, '0);
    check("rst_txdv", bus.o_tx_dv, 1'b0);
    check("rst_txdata", bus.o_tx_data, 8'h00);
    check("rst_overrun", overrun, 1'b0);

    send_byte(8'h52); send_byte(8'h03);
    get_resp("rd3", 8'h00, 1);
    check("rd3_regs", regs, '0);

    send_byte(8'h57); send_byte(8'h05); send_byte(8'hA5);
    model[5] = 8'hA5;
    check("wr5_regs_lat", regs[47:40], 8'hA5);
    get_resp("wr5", 8'h4B, 1);
    send_byte(8'h52); send_byte(8'h05);
    get_resp("rd5", 8'hA5, 1);

    send_byte(8'h41);
    get_resp("bad_op", 8'h3F, 1);

    send_byte(8'h57); send_byte(8'h10); send_byte(8'h77);
    get_resp("wr_oor", 8'h45, 1);
    check("wr_oor_regs", regs, model_flat());
    send_byte(8'h52); send_byte(8'hFF);
    get_resp("rd_oor", 8'h45, 1);

    send_byte(8'h57); send_byte(8'h02);
    quiet("tmo_quiet", TIMEOUT + 5);
    send_byte(8'h52); send_byte(8'h02);
    get_resp("tmo_rd2", 8'h00, 1);
    check("tmo_regs", regs, model_flat());

    // Data byte lands on the very cycle the timeout would fire.
    send_byte(8'h57); send_byte(8'h06);
    repeat (TIMEOUT - 2) @(negedge clk);
    send_byte(8'h3C);
    model[6] = 8'h3C;
    get_resp("tmo_edge", 8'h4B, 1);
    check("tmo_edge_regs", regs, model_flat());

    bus.i_tx_busy = 1'b1;
    send_byte(8'h52); send_byte(8'h05);
    ov = 0;
    dvc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (overrun) ov++;
      if (bus.o_tx_dv) dvc++;
      if (i == 10) begin
        bus.i_rx_data = 8'h41;
        bus.i_rx_dv   = 1'b1;
      end
      if (i == 11) bus.i_rx_dv = 1'b0;
    end
    check("busy_overrun", ov, 1);
    check("busy_no_tx", dvc, 0);
    bus.i_tx_busy = 1'b0;
    get_resp("busy_rd", 8'hA5, 1);
    quiet("drop_quiet", 10);

    send_byte(8'h57); send_byte(8'h01);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_txdv", bus.o_tx_dv, 1'b0);
    check("midrst_txdata", bus.o_tx_data, 8'h00);
    for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
    check("midrst_regs", regs, model_flat());
    send_byte(8'h5A);
    get_resp("midrst_data_as_op", 8'h3F, 1);
    check("midrst_reg1", regs[15:8], 8'h00);
    send_byte(8'h52); send_byte(8'h01);
    get_resp("midrst_rd1", 8'h00, 1);

    bus.i_tx_busy = 1'b1;
    send_byte(8'h41);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.i_tx_busy = 1'b0;
    quiet("resprst_quiet", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
